// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART blocks.
//   uart_rx_state_t : receiver FSM state encoding
//   uart_div()      : rounded clocks-per-bit, shared with the transmitter
//   UART_DATA_BITS  : data bits per frame
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- small synchronous FIFO for received bytes.
//   clk, rst        : core clock, synchronous active-high reset
//   push, wdata     : write request and data; ignored when full unless a pop
//                     happens in the same cycle (pop is applied first)
//   full            : DEPTH entries held
//   pop, rdata      : read request and head data; rdata is 0 while empty
//   empty           : no entries held
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; stale entries are unreachable because rdata is masked while empty and the count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver with receive FIFO.
// Frames are 8-N-1, or 8-E-1 when UART_RX_PARITY_EN is defined.
//   clk        : core clock
//   rst        : synchronous active-high reset
//   rx         : raw asynchronous serial input, idle high
//   data       : FIFO head byte, 0 while empty
//   valid      : FIFO non-empty
//   ready      : consumer takes data when valid && ready
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   parity_err : 1-cycle pulse, even-parity mismatch (0 without parity)
//   overrun    : 1-cycle pulse, byte dropped because the FIFO was full
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 3_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV < 4) ? 2 : $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (DIV < 4) begin : g_bad_div
        $error("uart_rx: CLK_HZ/BAUD gives fewer than 4 clocks per bit");
    end

    logic                      rx_meta_q, rx_meta_d;
    logic                      rxs_q,     rxs_d;
    logic [1:0]                fill_q,    fill_d;
    uart_rx_state_t            state_q,   state_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q,   overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_q,        par_d;
    logic                      parity_err_q, parity_err_d;
`endif

    logic cnt_zero;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    assign cnt_zero = (cnt_q == '0);
    assign valid    = !fifo_empty;
    assign pop      = valid && ready;

    always_comb begin
        rx_meta_d   = rx;
        rxs_d       = rx_meta_q;
        // The synchronizer's reset value of 1 is not a real line sample;
        // fill marks when both stages hold sampled data, so a line held
        // low through reset release is never taken for idle-then-start.
        fill_d      = {fill_q[0], 1'b1};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        // Drop the byte when it cannot enter; a same-cycle pop frees space.
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            WAIT_HIGH: begin
                if (fill_q[1] && rxs_q) state_d = IDLE;
            end
            IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rxs_q) begin
                        state_d = IDLE;           // glitch, not a start bit
                    end else begin
                        cnt_d     = CNT_FULL;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};  // LSB first
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_zero) begin
                    par_d   = rxs_q;
                    cnt_d   = CNT_FULL;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit keeps half a bit of margin for
                // a start edge that follows with no idle gap.
                if (cnt_zero) begin
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase

        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            fill_q      <= '0;
            state_q     <= WAIT_HIGH;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift_q),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (data),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx at default
// parameters (26 clocks per bit). Parity vectors run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DIV = 26;   // (3_000_000 + 57_600) / 115_200

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    // Monitor: log accepted bytes and count pulses, away from the edge.
    logic [7:0] rx_log [64];
    int rx_n     = 0;
    int n_valid  = 0;
    int n_fe     = 0;
    int n_pe     = 0;
    int n_ovr    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready && rx_n < 64) begin
                rx_log[rx_n] = data;
                rx_n++;
            end
            if (valid)      n_valid++;
            if (frame_err)  n_fe++;
            if (parity_err) n_pe++;
            if (overrun)    n_ovr++;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_bit);
        send_bit(1'b1);
    endtask
`endif

    // Byte at log position idx, or 0xFFFF when nothing was logged there.
    function automatic logic [31:0] logged(input int idx);
        if (idx < rx_n && idx < 64) return 32'(rx_log[idx]);
        return 32'hFFFF;
    endfunction

    int b_rx, b_valid, b_fe, b_pe, b_ovr;

    task automatic snap();
        b_rx = rx_n; b_valid = n_valid; b_fe = n_fe; b_pe = n_pe; b_ovr = n_ovr;
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data",   32'(data),       32'h0);
        check("rst_valid",  32'(valid),      32'h0);
        check("rst_fe",     32'(frame_err),  32'h0);
        check("rst_pe",     32'(parity_err), 32'h0);
        check("rst_ovr",    32'(overrun),    32'h0);
        tick(2 * DIV);

        // 1: two back-to-back bytes, consumer always ready.
        snap();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(DIV);
        check("b2b_count",  32'(rx_n - b_rx),       32'd2);
        check("b2b_byte0",  logged(b_rx),           32'hA5);
        check("b2b_byte1",  logged(b_rx + 1),       32'h3C);
        check("b2b_vcyc",   32'(n_valid - b_valid), 32'd2);
        check("b2b_errs",   32'((n_fe - b_fe) + (n_pe - b_pe) + (n_ovr - b_ovr)), 32'd0);

        // 2: fill the FIFO with the consumer stalled, then overrun.
        ready = 1'b0;
        snap();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        tick(4);
        check("ovr_none4",  32'(n_ovr - b_ovr), 32'd0);
        send_frame(8'h05, 1'b1);
        tick(4);
        @(negedge clk);
        check("ovr_once",   32'(n_ovr - b_ovr), 32'd1);
        check("ovr_valid",  32'(valid),         32'h1);
        check("ovr_head",   32'(data),          32'h01);
        tick(1);
        snap();
        ready = 1'b1;
        tick(4);
        ready = 1'b0;
        @(negedge clk);
        check("drain_cnt",  32'(rx_n - b_rx), 32'd4);
        for (int i = 0; i < 4; i++) check("drain_byte", logged(b_rx + i), 32'(i + 1));
        check("drain_empty", 32'(valid), 32'h0);
        tick(1);
        ready = 1'b1;

        // 3: stop bit low, line held low, then a good byte.
        snap();
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        tick(3 * DIV);
        rx = 1'b1;
        tick(2 * DIV);
        send_frame(8'h12, 1'b1);
        tick(DIV);
        check("fe_once",    32'(n_fe - b_fe),   32'd1);
        check("fe_count",   32'(rx_n - b_rx),   32'd1);
        check("fe_byte",    logged(b_rx),       32'h12);
        check("fe_pe",      32'(n_pe - b_pe),   32'd0);

        // 4: short glitch shorter than half a bit.
        snap();
        rx = 1'b0;
        tick(DIV / 2 - 2);
        rx = 1'b1;
        tick(2 * DIV);
        check("gl_valid",   32'(n_valid - b_valid), 32'd0);
        check("gl_errs",    32'((n_fe - b_fe) + (n_pe - b_pe) + (n_ovr - b_ovr)), 32'd0);
        check("gl_state",   32'(dut.state_q),   32'(IDLE));

        // 5: reset during bit 4, line held low through reset release.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b0;
        tick(DIV / 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(2 * DIV);
        check("rs_none",    32'(rx_n - b_rx),   32'd0);
        send_frame(8'h7E, 1'b1);
        tick(DIV);
        check("rs_count",   32'(rx_n - b_rx),   32'd1);
        check("rs_byte",    logged(b_rx),       32'h7E);
        check("rs_errs",    32'((n_fe - b_fe) + (n_pe - b_pe) + (n_ovr - b_ovr)), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, correct then wrong parity bit.
        snap();
        send_frame_par(8'h03, 1'b0);
        tick(DIV);
        check("par_ok_cnt", 32'(rx_n - b_rx),   32'd1);
        check("par_ok_byte", logged(b_rx),      32'h03);
        check("par_ok_pe",  32'(n_pe - b_pe),   32'd0);
        snap();
        send_frame_par(8'h03, 1'b1);
        tick(DIV);
        check("par_bad_pe", 32'(n_pe - b_pe),   32'd1);
        check("par_bad_cnt", 32'(rx_n - b_rx),  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
